// File: rtl/regfile_pkg.sv
// Shared defaults for the forwarding register file: widths and the entry-0
// reset pattern used when entry 0 is an ordinary register.
package regfile_pkg;

  localparam int DEFAULT_ADDR_SIZE = 2;
  localparam int DEFAULT_WORD_SIZE = 64;

  // Alternating 1010... pattern, sized to a 64-bit word.
  localparam logic [63:0] DEFAULT_RESET_R0 = {32{2'b10}};

  typedef logic [DEFAULT_WORD_SIZE-1:0] word_t;
  typedef logic [DEFAULT_ADDR_SIZE-1:0] addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by an accepted
// reserve at issue and cleared by the writeback write.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_SIZE,
  parameter int NUM_REG  = 2**ADDR_W,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write_en,
  input  logic [ADDR_W-1:0]  sel_write,
  input  logic               reserve_en,
  input  logic [ADDR_W-1:0]  sel_reserve,
  output logic               reserve_ok,
  output logic [NUM_REG-1:0] busy_next
);

  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_d;

  // A reserve on a busy entry is still granted when the same edge retires it.
  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so later assignments override earlier ones and no latch is inferred.
  always_comb begin
    reserve_ok = reserve_en &
                 (~busy_q[sel_reserve] | (write_en & (sel_write == sel_reserve)));
    busy_d = busy_q;
    if (write_en) begin
      busy_d[sel_write] = 1'b0;
    end
    // Applied after the clear so a same-edge reservation wins over the write.
    if (reserve_ok) begin
      busy_d[sel_reserve] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_next = busy_d;

endmodule

// File: rtl/forwarding_register_file.sv
// Two-read, one-write register file with registered reads, same-edge
// write-to-read forwarding and a pending-write scoreboard for hazard checks.
module forwarding_register_file
  import regfile_pkg::*;
#(
  parameter int                       REG_ADDRESS_SIZE = DEFAULT_ADDR_SIZE,
  parameter int                       NUM_REG          = 2**REG_ADDRESS_SIZE,
  parameter int                       MEM_WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter bit                       ZERO_REG         = 1'b0,
  parameter logic [MEM_WORD_SIZE-1:0] RESET_R0         = MEM_WORD_SIZE'(DEFAULT_RESET_R0)
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic [REG_ADDRESS_SIZE-1:0] selA,
  input  logic [REG_ADDRESS_SIZE-1:0] selB,
  input  logic                        readEn,
  output logic [MEM_WORD_SIZE-1:0]    outA,
  output logic [MEM_WORD_SIZE-1:0]    outB,
  output logic                        busyA,
  output logic                        busyB,
  input  logic                        writeEn,
  input  logic [REG_ADDRESS_SIZE-1:0] selWrite,
  input  logic [MEM_WORD_SIZE-1:0]    writeIn,
  input  logic                        reserveEn,
  input  logic [REG_ADDRESS_SIZE-1:0] selReserve,
  output logic                        reserveOk
);

  logic [MEM_WORD_SIZE-1:0] regs_q [NUM_REG];
  logic [MEM_WORD_SIZE-1:0] regs_d [NUM_REG];

  logic [MEM_WORD_SIZE-1:0] out_a_q, out_a_d;
  logic [MEM_WORD_SIZE-1:0] out_b_q, out_b_d;
  logic                     busy_a_q, busy_a_d;
  logic                     busy_b_q, busy_b_d;

  logic [MEM_WORD_SIZE-1:0] fwd_a, fwd_b;
  logic [NUM_REG-1:0]       busy_next;
  logic                     write_hits_storage;

  reg_scoreboard #(
    .ADDR_W   (REG_ADDRESS_SIZE),
    .NUM_REG  (NUM_REG),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rstN),
    .write_en    (writeEn),
    .sel_write   (selWrite),
    .reserve_en  (reserveEn),
    .sel_reserve (selReserve),
    .reserve_ok  (reserveOk),
    .busy_next   (busy_next)
  );

  // A hardwired-zero entry 0 never takes a write.
  assign write_hits_storage = writeEn & ~(ZERO_REG && (selWrite == '0));

  always_comb begin
    regs_d = regs_q;
    if (write_hits_storage) begin
      regs_d[selWrite] = writeIn;
    end
  end

  // Operand values as they will be after this edge, so a read issued alongside
  // the writeback sees the new data without a bubble.
  always_comb begin
    fwd_a = regs_q[selA];
    if (writeEn && (selWrite == selA)) begin
      fwd_a = writeIn;
    end
    if (ZERO_REG && (selA == '0)) begin
      fwd_a = '0;
    end

    fwd_b = regs_q[selB];
    if (writeEn && (selWrite == selB)) begin
      fwd_b = writeIn;
    end
    if (ZERO_REG && (selB == '0)) begin
      fwd_b = '0;
    end
  end

  always_comb begin
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    busy_a_d = busy_a_q;
    busy_b_d = busy_b_q;
    if (readEn) begin
      out_a_d  = fwd_a;
      out_b_d  = fwd_b;
      busy_a_d = busy_next[selA];
      busy_b_d = busy_next[selB];
    end
  end

  // NOTE: the storage array is reset entry by entry because the reset
  // contents are architecturally visible; this keeps it in flops, not RAM.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs_q[i] <= ((i == 0) && !ZERO_REG) ? RESET_R0 : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_a_q  <= '0;
      out_b_q  <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
    end else begin
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      busy_a_q <= busy_a_d;
      busy_b_q <= busy_b_d;
    end
  end

  assign outA  = out_a_q;
  assign outB  = out_b_q;
  assign busyA = busy_a_q;
  assign busyB = busy_b_q;

endmodule

// File: tb/tb_forwarding_register_file.sv
// Directed bench: a default instance and a ZERO_REG=1 instance share one
// stimulus stream; each scenario task checks hand-computed results inline.
module tb_forwarding_register_file;

  logic        clk;
  logic        rstN;
  logic [1:0]  selA, selB, selWrite, selReserve;
  logic        readEn, writeEn, reserveEn;
  logic [63:0] writeIn;

  logic [63:0] outA, outB, z_outA, z_outB;
  logic        busyA, busyB, z_busyA, z_busyB;
  logic        reserveOk, z_reserveOk;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] R0_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

  forwarding_register_file dut (
    .clk(clk), .rstN(rstN), .selA(selA), .selB(selB), .readEn(readEn),
    .outA(outA), .outB(outB), .busyA(busyA), .busyB(busyB),
    .writeEn(writeEn), .selWrite(selWrite), .writeIn(writeIn),
    .reserveEn(reserveEn), .selReserve(selReserve), .reserveOk(reserveOk)
  );

  forwarding_register_file #(.ZERO_REG(1'b1)) dut_zero (
    .clk(clk), .rstN(rstN), .selA(selA), .selB(selB), .readEn(readEn),
    .outA(z_outA), .outB(z_outB), .busyA(z_busyA), .busyB(z_busyB),
    .writeEn(writeEn), .selWrite(selWrite), .writeIn(writeIn),
    .reserveEn(reserveEn), .selReserve(selReserve), .reserveOk(z_reserveOk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    readEn = 0; writeEn = 0; reserveEn = 0;
    selA = 0; selB = 0; selWrite = 0; selReserve = 0; writeIn = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] exp_a, z_exp_a, exp_b;
    idle();
    rstN = 0;
    #12;
    total++;
    if (outA !== 64'h0 || outB !== 64'h0 || busyA !== 1'b0 || busyB !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs actual=%h/%h/%b/%b expected=0/0/0/0", outA, outB, busyA, busyB);
    end
    @(negedge clk);
    rstN = 1;
    for (int i = 0; i < 4; i++) begin
      selA = 2'(i); selB = 2'(3 - i); readEn = 1;
      step();
      exp_a   = (i == 0) ? R0_PATTERN : 64'h0;
      exp_b   = (i == 3) ? R0_PATTERN : 64'h0;
      z_exp_a = 64'h0;
      total++;
      if (outA !== exp_a || outB !== exp_b || busyA !== 1'b0 || busyB !== 1'b0) begin
        bad++;
        $display("FAIL reset_read_%0d actual=%h/%h/%b/%b expected=%h/%h/0/0",
                 i, outA, outB, busyA, busyB, exp_a, exp_b);
      end
      total++;
      if (z_outA !== z_exp_a || z_busyA !== 1'b0) begin
        bad++;
        $display("FAIL reset_read_zero_%0d actual=%h/%b expected=%h/0", i, z_outA, z_busyA, z_exp_a);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    writeEn = 1; selWrite = 2; writeIn = 64'h1234;
    step();
    idle();
    selA = 2; readEn = 1;
    step();
    total++;
    if (outA !== 64'h1234 || z_outA !== 64'h1234) begin
      bad++;
      $display("FAIL write_read actual=%h/%h expected=1234/1234", outA, z_outA);
    end
    // readEn low: outputs must hold while the address moves.
    idle();
    selA = 1;
    step();
    total++;
    if (outA !== 64'h1234) begin
      bad++;
      $display("FAIL read_hold actual=%h expected=1234", outA);
    end
  endtask

  task automatic test_forwarding();
    writeEn = 1; selWrite = 1; writeIn = 64'hDEAD;
    readEn = 1; selA = 1; selB = 1;
    step();
    total++;
    if (outA !== 64'hDEAD || outB !== 64'hDEAD || busyA !== busyB) begin
      bad++;
      $display("FAIL forward_same_edge actual=%h/%h expected=dead/dead", outA, outB);
    end
    idle();
    readEn = 1; selA = 1; selB = 2;
    step();
    total++;
    if (outA !== 64'hDEAD || outB !== 64'h1234) begin
      bad++;
      $display("FAIL forward_stored actual=%h/%h expected=dead/1234", outA, outB);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    reserveEn = 1; selReserve = 3;
    #1;
    total++;
    if (reserveOk !== 1'b1 || z_reserveOk !== 1'b1) begin
      bad++;
      $display("FAIL reserve_first actual=%b/%b expected=1/1", reserveOk, z_reserveOk);
    end
    step();
    #1;
    total++;
    if (reserveOk !== 1'b0 || z_reserveOk !== 1'b0) begin
      bad++;
      $display("FAIL reserve_second actual=%b/%b expected=0/0", reserveOk, z_reserveOk);
    end
    step();
    idle();
    readEn = 1; selA = 3; selB = 3;
    step();
    total++;
    if (busyA !== 1'b1 || busyB !== 1'b1 || z_busyA !== 1'b1) begin
      bad++;
      $display("FAIL busy_read actual=%b/%b/%b expected=1/1/1", busyA, busyB, z_busyA);
    end
    // Write and re-reserve entry 3 on one edge: reservation wins.
    idle();
    writeEn = 1; selWrite = 3; writeIn = 64'h33;
    reserveEn = 1; selReserve = 3;
    #1;
    total++;
    if (reserveOk !== 1'b1) begin
      bad++;
      $display("FAIL reserve_with_write actual=%b expected=1", reserveOk);
    end
    step();
    idle();
    readEn = 1; selA = 3;
    step();
    total++;
    if (busyA !== 1'b1 || outA !== 64'h33) begin
      bad++;
      $display("FAIL busy_after_write_reserve actual=%b/%h expected=1/33", busyA, outA);
    end
    // Plain write clears busy; a same-edge read reports the cleared bit.
    idle();
    writeEn = 1; selWrite = 3; writeIn = 64'h44;
    readEn = 1; selA = 3;
    step();
    total++;
    if (busyA !== 1'b0 || outA !== 64'h44) begin
      bad++;
      $display("FAIL busy_cleared actual=%b/%h expected=0/44", busyA, outA);
    end
    // Same-edge reserve is visible to a same-edge read.
    idle();
    reserveEn = 1; selReserve = 2; readEn = 1; selA = 2; selB = 1;
    step();
    total++;
    if (busyA !== 1'b1 || busyB !== 1'b0) begin
      bad++;
      $display("FAIL busy_same_edge_reserve actual=%b/%b expected=1/0", busyA, busyB);
    end
    // Busy entry with an unrelated write is still rejected.
    idle();
    reserveEn = 1; selReserve = 2; writeEn = 1; selWrite = 1; writeIn = 64'hDEAD;
    #1;
    total++;
    if (reserveOk !== 1'b0) begin
      bad++;
      $display("FAIL reserve_other_write actual=%b expected=0", reserveOk);
    end
    idle();
    writeEn = 1; selWrite = 2; writeIn = 64'h1234;
    step();
    idle();
  endtask

  task automatic test_zero_reg();
    writeEn = 1; selWrite = 0; writeIn = 64'hFFFF;
    reserveEn = 1; selReserve = 0;
    #1;
    total++;
    if (z_reserveOk !== 1'b1 || reserveOk !== 1'b1) begin
      bad++;
      $display("FAIL zero_reserve actual=%b/%b expected=1/1", z_reserveOk, reserveOk);
    end
    step();
    idle();
    readEn = 1; selA = 0; selB = 0;
    step();
    total++;
    if (z_outA !== 64'h0 || z_busyA !== 1'b0 || z_outB !== 64'h0) begin
      bad++;
      $display("FAIL zero_read actual=%h/%b expected=0/0", z_outA, z_busyA);
    end
    total++;
    if (outA !== 64'hFFFF || busyA !== 1'b1) begin
      bad++;
      $display("FAIL r0_plain_read actual=%h/%b expected=ffff/1", outA, busyA);
    end
    idle();
    reserveEn = 1; selReserve = 0;
    #1;
    total++;
    if (z_reserveOk !== 1'b1 || reserveOk !== 1'b0) begin
      bad++;
      $display("FAIL zero_rereserve actual=%b/%b expected=1/0", z_reserveOk, reserveOk);
    end
    idle();
  endtask

  task automatic test_async_reset();
    writeEn = 1; selWrite = 2; writeIn = 64'h55;
    reserveEn = 1; selReserve = 1;
    readEn = 1; selA = 2; selB = 1;
    step();
    total++;
    if (outA !== 64'h55 || busyB !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state actual=%h/%b expected=55/1", outA, busyB);
    end
    // Pending write/reserve at the next edge must be lost.
    writeEn = 1; selWrite = 3; writeIn = 64'h99;
    #2;
    rstN = 0;
    #1;
    total++;
    if (outA !== 64'h0 || outB !== 64'h0 || busyA !== 1'b0 || busyB !== 1'b0) begin
      bad++;
      $display("FAIL async_reset actual=%h/%h/%b/%b expected=0/0/0/0", outA, outB, busyA, busyB);
    end
    idle();
    @(negedge clk);
    rstN = 1;
    readEn = 1; selA = 2; selB = 1; reserveEn = 1; selReserve = 1;
    #1;
    total++;
    if (reserveOk !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_reserve actual=%b expected=1", reserveOk);
    end
    reserveEn = 0;
    step();
    total++;
    if (outA !== 64'h0 || busyB !== 1'b0 || outB !== 64'h0) begin
      bad++;
      $display("FAIL post_reset_read actual=%h/%h/%b expected=0/0/0", outA, outB, busyB);
    end
    idle();
    readEn = 1; selA = 0; selB = 3;
    step();
    total++;
    if (outA !== R0_PATTERN || outB !== 64'h0) begin
      bad++;
      $display("FAIL post_reset_r0 actual=%h/%h expected=%h/0", outA, outB, R0_PATTERN);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forwarding();
    test_scoreboard();
    test_zero_reg();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
